// File: rtl/alu_shift_seq.sv
// alu_shift_seq: iterative SLL/SRL/SRA sequencer, at most STEP bits per cycle.
// ALU_SHIFT_SEQ_ZERO_BYPASS_EN: zero-amount requests skip the SHIFT state.
module alu_shift_seq #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [XLEN-1:0]         i_data,
    input  logic [$clog2(XLEN)-1:0] i_shamt,
    input  logic [1:0]              i_op,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [XLEN-1:0]         o_result,
    output logic                    o_busy
);
    localparam int SW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [XLEN-1:0] work, work_nx, shl, shr, sra;
    logic [SW-1:0] rem, rem_nx, step;
    logic [1:0] op, op_nx;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            work  <= '0;
            rem   <= '0;
            op    <= '0;
        end else begin
            state <= state_nx;
            work  <= work_nx;
            rem   <= rem_nx;
            op    <= op_nx;
        end
    end
    // SRA keeps the sign bit in place, so the working MSB is the captured sign
    assign step = (rem < SW'(STEP)) ? rem : SW'(STEP);
    assign shl  = work << step;
    assign shr  = work >> step;
    assign sra  = $signed(work) >>> step;
    always_comb begin
        state_nx = state;
        work_nx  = work;
        rem_nx   = rem;
        op_nx    = op;
        case (state)
            IDLE: if (i_valid) begin
                work_nx  = i_data;
                rem_nx   = i_shamt;
                op_nx    = i_op;
                state_nx = SHIFT;
`ifdef ALU_SHIFT_SEQ_ZERO_BYPASS_EN
                if (i_shamt == '0) state_nx = DONE;
`endif
            end
            SHIFT: begin
                rem_nx   = rem - step;
                work_nx  = (op == 2'b00) ? shl : (op == 2'b01) ? shr : (op == 2'b10) ? sra : work;
                state_nx = (rem == step) ? DONE : SHIFT;
            end
            DONE: if (i_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    assign o_ready  = (state == IDLE);
    assign o_valid  = (state == DONE);
    assign o_busy   = (state != IDLE);
    assign o_result = work;
endmodule
